// File: rtl/bit_counter_fsm.sv
// -----------------------------------------------------------------------------
// bit_counter_fsm
//   Counts the ones (mode=0) or zeros (mode=1) in an N-bit word using a
//   shift-right datapath. The word is taken on a start/done handshake.
//   Ones mode stops early as soon as the remaining shifted word is zero.
//   Zeros mode always examines all N bits.
//
// Parameters
//   N    data word width (N >= 2)
//   CW   count width, holds 0..N
//
// Ports
//   Clk    in   system clock, rising edge
//   Reset  in   synchronous, active-high reset
//   s      in   start request, held high until Done is seen
//   mode   in   0 = count ones, 1 = count zeros (sampled with s)
//   Data   in   N-bit word to count (sampled with s)
//   B      out  result count (registered)
//   Done   out  result valid (registered)
//   Busy   out  high while counting (registered)
//   P      out  ones parity of the sampled word, present only when
//               BIT_COUNTER_PARITY_EN is defined
//
// States
//   ST_IDLE  | waiting for s; B holds the previous result
//   ST_COUNT | shifting A right, accumulating B
//   ST_DONE  | result valid, waiting for s to drop
// -----------------------------------------------------------------------------
module bit_counter_fsm #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          s,
  input  logic          mode,
  input  logic [N-1:0]  Data,
  output logic [CW-1:0] B,
  output logic          Done,
`ifdef BIT_COUNTER_PARITY_EN
  output logic          P,
`endif
  output logic          Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] N_CW = CW'(N);

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_b;
  logic          r_done;
  logic          r_busy;
  logic          r_mode_q;

  state_t        w_state_nxt;
  logic [N-1:0]  w_a_nxt;
  logic [CW-1:0] w_idx_nxt;
  logic [CW-1:0] w_b_nxt;
  logic          w_done_nxt;
  logic          w_busy_nxt;
  logic          w_mode_q_nxt;
  logic          w_term;

`ifdef BIT_COUNTER_PARITY_EN
  logic          r_p;
  logic          w_p_nxt;
`endif

  // Ones mode is finished once no set bits remain; zeros mode must look at
  // every bit because leading zeros still count.
  assign w_term = (!r_mode_q && (r_a == '0)) || (r_mode_q && (r_idx == N_CW));

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_idx_nxt    = r_idx;
    w_b_nxt      = r_b;
    w_done_nxt   = r_done;
    w_busy_nxt   = r_busy;
    w_mode_q_nxt = r_mode_q;
`ifdef BIT_COUNTER_PARITY_EN
    w_p_nxt      = r_p;
`endif

    case (r_state)
      ST_IDLE: begin
        w_done_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        if (s) begin
          w_a_nxt      = Data;
          w_mode_q_nxt = mode;
          w_b_nxt      = '0;
          w_idx_nxt    = '0;
          w_busy_nxt   = 1'b1;
`ifdef BIT_COUNTER_PARITY_EN
          w_p_nxt      = 1'b0;
`endif
          w_state_nxt  = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (w_term) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_a_nxt   = r_a >> 1;
          w_idx_nxt = r_idx + CW'(1);
          // Examined bit differs from mode_q exactly when it is the value
          // being counted (1 in ones mode, 0 in zeros mode).
          if (r_a[0] != r_mode_q) begin
            w_b_nxt = r_b + CW'(1);
          end
`ifdef BIT_COUNTER_PARITY_EN
          // Every set bit is shifted through bit 0 before termination in
          // either mode, so this always ends as the full ones parity.
          w_p_nxt = r_p ^ r_a[0];
`endif
        end
      end

      ST_DONE: begin
        w_done_nxt = 1'b1;
        if (!s) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_idx    <= '0;
      r_b      <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_mode_q <= 1'b0;
`ifdef BIT_COUNTER_PARITY_EN
      r_p      <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_idx    <= w_idx_nxt;
      r_b      <= w_b_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_mode_q <= w_mode_q_nxt;
`ifdef BIT_COUNTER_PARITY_EN
      r_p      <= w_p_nxt;
`endif
    end
  end

  assign B    = r_b;
  assign Done = r_done;
  assign Busy = r_busy;
`ifdef BIT_COUNTER_PARITY_EN
  assign P    = r_p;
`endif

endmodule

// File: tb/tb_bit_counter_fsm.sv
// -----------------------------------------------------------------------------
// tb_bit_counter_fsm
//   Directed bench for bit_counter_fsm with an N=8 and an N=5 instance.
//   Expected counts, latencies and parities are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_bit_counter_fsm;

  logic       clk = 1'b0;
  logic       rst;

  logic       s8, m8;
  logic [7:0] d8;
  logic [3:0] b8;
  logic       done8, busy8;

  logic       s5, m5;
  logic [4:0] d5;
  logic [2:0] b5;
  logic       done5, busy5;

`ifdef BIT_COUNTER_PARITY_EN
  logic       p8, p5;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bit_counter_fsm #(.N(8)) dut8 (
    .Clk   (clk),
    .Reset (rst),
    .s     (s8),
    .mode  (m8),
    .Data  (d8),
    .B     (b8),
    .Done  (done8),
`ifdef BIT_COUNTER_PARITY_EN
    .P     (p8),
`endif
    .Busy  (busy8)
  );

  bit_counter_fsm #(.N(5)) dut5 (
    .Clk   (clk),
    .Reset (rst),
    .s     (s5),
    .mode  (m5),
    .Data  (d5),
    .B     (b5),
    .Done  (done5),
`ifdef BIT_COUNTER_PARITY_EN
    .P     (p5),
`endif
    .Busy  (busy5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full handshake: start, scramble inputs after sampling, wait for Done,
  // hold s one more cycle, then drop s and check Done falls while B holds.
  task automatic run_op(input bit sel5, input logic [7:0] d, input logic m,
                        input int exp_b, input int exp_lat, input logic exp_p,
                        input string tag);
    int lat;
    @(negedge clk);
    if (sel5) begin s5 = 1'b1; m5 = m; d5 = d[4:0]; end
    else      begin s8 = 1'b1; m8 = m; d8 = d;      end
    @(posedge clk); #1;
    chk({tag, "_busy_start"}, sel5 ? busy5 : busy8, 1);
    @(negedge clk);
    if (sel5) begin m5 = ~m; d5 = ~d[4:0]; end
    else      begin m8 = ~m; d8 = ~d;      end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(sel5 ? done5 : done8) && lat < 40);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_count"}, sel5 ? {1'b0, b5} : b8, exp_b);
    chk({tag, "_busy_end"}, sel5 ? busy5 : busy8, 0);
`ifdef BIT_COUNTER_PARITY_EN
    chk({tag, "_parity"}, sel5 ? p5 : p8, exp_p);
`else
    if (exp_p === 1'bx) $display("unexpected parity value");
`endif
    @(posedge clk); #1;
    chk({tag, "_done_hold"}, sel5 ? done5 : done8, 1);
    @(negedge clk);
    if (sel5) s5 = 1'b0; else s8 = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, sel5 ? done5 : done8, 0);
    chk({tag, "_count_kept"}, sel5 ? {1'b0, b5} : b8, exp_b);
  endtask

  initial begin
    rst = 1'b1;
    s8 = 1'b0; m8 = 1'b0; d8 = '0;
    s5 = 1'b0; m5 = 1'b0; d5 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b8",    b8,    0);
    chk("rst_done8", done8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_b5",    b5,    0);
    chk("rst_done5", done5, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of counting 8'hFF.
    @(negedge clk);
    s8 = 1'b1; m8 = 1'b0; d8 = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("midrst_busy_before", busy8, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_b",    b8,    0);
    chk("midrst_done", done8, 0);
    chk("midrst_busy", busy8, 0);
    @(negedge clk);
    rst = 1'b0;
    s8  = 1'b0;

    //        sel   data          mode  B  lat  P
    run_op(1'b0, 8'h0F,        1'b0, 4, 5, 1'b0, "ones_0F");
    run_op(1'b0, 8'b1011_0010, 1'b0, 4, 9, 1'b0, "ones_B2");
    run_op(1'b0, 8'h00,        1'b0, 0, 1, 1'b0, "ones_00");
    run_op(1'b0, 8'h01,        1'b0, 1, 2, 1'b1, "ones_01");
    run_op(1'b0, 8'h81,        1'b1, 6, 9, 1'b0, "zeros_81");
    run_op(1'b0, 8'hFF,        1'b1, 0, 9, 1'b0, "zeros_FF");
    run_op(1'b0, 8'h00,        1'b1, 8, 9, 1'b0, "zeros_00");
    run_op(1'b0, 8'hFF,        1'b0, 8, 9, 1'b0, "ones_FF");
    run_op(1'b1, 8'h1F,        1'b0, 5, 6, 1'b1, "n5_ones_1F");
    run_op(1'b1, 8'h00,        1'b1, 5, 6, 1'b0, "n5_zeros_00");
    run_op(1'b0, 8'b0111_0000, 1'b0, 3, 8, 1'b1, "par_ones_70");
    run_op(1'b0, 8'b0111_0000, 1'b1, 5, 9, 1'b1, "par_zeros_70");
    run_op(1'b0, 8'h00,        1'b0, 0, 1, 1'b0, "par_ones_00");

    // Idle with s low: Done stays low and B keeps the last result.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_done", done8, 0);
    chk("idle_b",    b8,    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
